// File: rtl/sw_debounce_mmio.sv
// Slide-switch MMIO peripheral: 2-flop sync, per-bit debounce, sticky change flags
// and an accept-event counter behind a 16-byte register window.
module sw_debounce_mmio #(
    parameter int          WIDTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [15:0] BASE_ADDR       = 16'hA010
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_sw,
    input  logic [31:0]      i_addr,
    input  logic             i_read,
    input  logic             i_write,
    input  logic [31:0]      i_wrdata,
    output logic [31:0]      o_rddata,
    output logic             o_irq,
    output logic [WIDTH-1:0] o_sw_stable
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_CHANGED = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;

    logic [WIDTH-1:0]            sync1, sync2, stable, changed;
    logic [WIDTH-1:0]            accept, clr_mask;
    logic [WIDTH-1:0][CNT_W-1:0] cnt;
    logic [15:0]                 count;
    logic                        hit, wr_changed, wr_count;
    logic [1:0]                  sel;
    logic [31:0]                 rd_mux;
    logic                        unused_bits;

    assign hit        = (i_addr[15:4] == BASE_ADDR[15:4]);
    assign sel        = i_addr[3:2];
    assign wr_changed = i_write && hit && (sel == REG_CHANGED);
    assign wr_count   = i_write && hit && (sel == REG_COUNT);
    assign clr_mask   = wr_changed ? i_wrdata[WIDTH-1:0] : '0;
    assign unused_bits = ^{i_addr[31:16], i_addr[1:0], i_wrdata[31:WIDTH]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_sw;
            sync2 <= sync1;
        end
    end

    // Accept fires on the DEBOUNCE_CYCLES-th consecutive cycle sync2 disagrees with stable.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++)
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i] || cnt[i] == CNT_MAX)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable  <= '0;
            changed <= '0;
        end else begin
            stable  <= stable ^ accept;
            changed <= (changed & ~clr_mask) | accept;
        end
    end

    // A clear that lands on an accept cycle still counts that accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (wr_count)
            count <= {15'b0, |accept};
        else if (|accept)
            count <= count + 16'd1;
    end

    always_comb begin
        rd_mux = '0;
        case (sel)
            REG_DATA:    rd_mux = 32'(stable);
            REG_CHANGED: rd_mux = 32'(changed);
            REG_COUNT:   rd_mux = {16'b0, count};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            o_rddata <= '0;
        else
            o_rddata <= (i_read && hit) ? rd_mux : '0;
    end

    assign o_irq       = |changed;
    assign o_sw_stable = stable;

endmodule

// File: tb/tb_sw_debounce_mmio.sv
// Bench for sw_debounce_mmio: window-based reference model feeds an expected-read queue,
// a negedge monitor checks read data, stable value and irq every cycle.
module tb_sw_debounce_mmio;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  i_sw = '0;
    logic [31:0] i_addr = '0;
    logic        i_read = 1'b0;
    logic        i_write = 1'b0;
    logic [31:0] i_wrdata = '0;
    logic [31:0] o_rddata;
    logic        o_irq;
    logic [7:0]  o_sw_stable;

    int checks = 0;
    int errors = 0;

    sw_debounce_mmio #(.WIDTH(8), .DEBOUNCE_CYCLES(N), .BASE_ADDR(16'hA010)) dut (
        .clk(clk), .reset(reset), .i_sw(i_sw), .i_addr(i_addr), .i_read(i_read),
        .i_write(i_write), .i_wrdata(i_wrdata), .o_rddata(o_rddata), .o_irq(o_irq),
        .o_sw_stable(o_sw_stable)
    );

    always #5 clk = ~clk;

    // Reference model: hist holds raw switch samples per edge; the synchroniser
    // makes the value seen at edge t equal to the sample from edge t-2.
    logic [7:0]  hist[$];
    logic [7:0]  m_stable, m_changed;
    logic [15:0] m_count;
    logic [31:0] exp_q[$];

    function automatic logic m_hit(input logic [31:0] a);
        return a[15:4] == 12'hA01;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {24'h0, m_stable};
            2'd1:    return {24'h0, m_changed};
            2'd2:    return {16'h0, m_count};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        hist.delete();
        for (int k = 0; k < N + 2; k++) hist.push_back(8'h00);
        m_stable = '0;
        m_changed = '0;
        m_count = '0;
        exp_q.delete();
    endtask

    task automatic m_step();
        logic [7:0] acc;
        logic       all_diff;
        acc = '0;
        if (i_read) exp_q.push_back(m_read(i_addr));
        hist.push_back(i_sw);
        // A bit is accepted when each of the last N synchronised samples differs from stable.
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= N; k++)
                if (hist[k][b] == m_stable[b]) all_diff = 1'b0;
            acc[b] = all_diff;
        end
        void'(hist.pop_front());
        if (i_write && m_hit(i_addr) && i_addr[3:2] == 2'd1) m_changed = m_changed & ~i_wrdata[7:0];
        m_changed = m_changed | acc;
        if (i_write && m_hit(i_addr) && i_addr[3:2] == 2'd2) m_count = (acc != 0) ? 16'd1 : 16'd0;
        else if (acc != 0) m_count = m_count + 16'd1;
        m_stable = m_stable ^ acc;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            chk("sw_stable", {24'h0, o_sw_stable}, {24'h0, m_stable});
            chk("irq", {31'h0, o_irq}, {31'h0, |m_changed});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rddata", o_rddata, e);
            end else begin
                chk("rddata_idle", o_rddata, 32'h0);
            end
        end
    end

    task automatic rd(input logic [31:0] a);
        i_addr = a; i_read = 1'b1;
        @(negedge clk);
        i_read = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        i_addr = a; i_wrdata = d; i_write = 1'b1;
        @(negedge clk);
        i_write = 1'b0;
    endtask

    task automatic rw(input logic [31:0] a, input logic [31:0] d);
        i_addr = a; i_wrdata = d; i_write = 1'b1; i_read = 1'b1;
        @(negedge clk);
        i_write = 1'b0; i_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges from a raw change (driven at a negedge) until o_sw_stable shows tgt.
    task automatic lat(input string nm, input logic [7:0] tgt, input int expn);
        int n;
        n = 0;
        while (o_sw_stable !== tgt && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n, expn);
    endtask

    logic [31:0] addrs[7] = '{32'hA010, 32'hA014, 32'hA018, 32'hA01C, 32'hA000,
                              32'hA020, 32'h1234A014};

    initial begin
        idle(3);
        reset = 1'b0;
        // reset state
        rd(32'hA010); rd(32'hA014); rd(32'hA018);

        // 0x00 -> 0x05, six-edge latency
        i_sw = 8'h05;
        lat("latency_05", 8'h05, N + 2);
        rd(32'hA010); rd(32'hA014); rd(32'hA018);

        // glitch on bit 7 shorter than the debounce window
        i_sw = 8'h85; idle(3);
        i_sw = 8'h05; idle(6);
        rd(32'hA010); rd(32'hA014); rd(32'hA018);
        i_sw = 8'h85;
        lat("latency_after_glitch", 8'h85, N + 2);
        i_sw = 8'h05; idle(8);

        // W1C, then clear racing a fresh accept of bit 2
        wr(32'hA014, 32'h81); rd(32'hA014);
        i_sw = 8'h01; idle(5);
        wr(32'hA014, 32'h04); rd(32'hA014);

        // unmapped reads, ignored DATA write, read+write same cycle
        rd(32'hA000); rd(32'hA01C); rd(32'hA020);
        wr(32'hA010, 32'hFF); rd(32'hA010);
        rw(32'hA014, 32'hFF); rd(32'hA014);
        rw(32'hA018, 32'h0); rd(32'hA018);

        // reset mid-debounce of 0x00 -> 0xFF
        i_sw = 8'h00; idle(8);
        i_sw = 8'hFF;
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        lat("latency_after_reset", 8'hFF, N + 2);
        rd(32'hA010); rd(32'hA014); rd(32'hA018);

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0) i_sw = 8'($urandom);
            i_addr   = addrs[$urandom_range(0, 6)];
            i_wrdata = $urandom;
            i_read   = ($urandom_range(0, 2) == 0);
            i_write  = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        i_read = 1'b0; i_write = 1'b0;

        // one accept per cycle on staggered bits 0..3 to wrap COUNT
        i_sw = 8'h00; idle(10);
        wr(32'hA018, 32'h0);
        for (int c = 0; c < 65560; c++) begin
            i_sw = i_sw ^ (8'h01 << (c % 4));
            i_read = 1'b0; i_write = 1'b0;
            if (c == 100 || c == 65538 || c == 65549) begin i_addr = 32'hA018; i_read = 1'b1; end
            if (c == 65548) begin i_addr = 32'hA018; i_wrdata = 32'h0; i_write = 1'b1; end
            @(negedge clk);
        end
        i_read = 1'b0; i_write = 1'b0;
        idle(10);
        rd(32'hA018);
        idle(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

endmodule
